// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: the in-flight writer
// entry, forwarding-select constants and the register-match helper.
package mips_pipe_pkg;

    localparam int DEF_REG_AW  = 5;
    localparam int DEF_NSTAGE  = 3;

    // Forwarding-select codes: 0 reads the register file, NSTAGE reads the
    // retired-write holding register, values in between name a stage output.
    localparam int FWD_RF      = 0;
    localparam int FWD_RETIRED = DEF_NSTAGE;

    // One tracked instruction between EX and WB.
    typedef struct packed {
        logic                  v;   // entry holds a real instruction
        logic [DEF_REG_AW-1:0] rw;  // destination register
        logic                  we;  // writes the register file
        logic                  ld;  // is a load
    } pipe_entry_t;

    // A writer is relevant only if it is live, really writes, the source is
    // actually read, and the register is not r0 (which is hard-wired zero).
    function automatic logic entry_matches(input pipe_entry_t           e,
                                           input logic [DEF_REG_AW-1:0] src,
                                           input logic                  used);
        return e.v && e.we && used && (src != '0) && (e.rw == src);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clr wins.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    // Count register; holding at all-ones keeps the value from wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding controller for the pipelined MIPS core. Tracks every
// in-flight writer from EX to WB, produces registered forwarding selects,
// load-use stalls, taken-branch flushes and stall/flush counters.
module pipe_hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int LOAD_LAT = 2,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 16,
    localparam int FWD_W   = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              br_taken,
    input  logic              ext_stall,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic [FWD_W-1:0]  fwd_a_sel,
    output logic [FWD_W-1:0]  fwd_b_sel,
    output logic [NSTAGE-1:0] stg_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_entry_t [NSTAGE-1:0] ent_q, ent_d;
    logic [FWD_W-1:0]         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [FWD_W-1:0]         src_a_fwd, src_b_fwd;
    logic                     lu_hit, load_use, issue;

    // Youngest-writer search for both sources, plus load-use detection.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        src_a_fwd = FWD_W'(FWD_RF);
        src_b_fwd = FWD_W'(FWD_RF);
        lu_hit    = 1'b0;
        // Walk oldest to youngest so the youngest match is the one left standing.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (entry_matches(ent_q[k], id_rs, id_rs_used)) begin
                src_a_fwd = FWD_W'(k + 1);
                if (ent_q[k].ld && (k + 1 < LOAD_LAT)) lu_hit = 1'b1;
            end
            if (entry_matches(ent_q[k], id_rt, id_rt_used)) begin
                src_b_fwd = FWD_W'(k + 1);
                if (ent_q[k].ld && (k + 1 < LOAD_LAT)) lu_hit = 1'b1;
            end
        end
    end

    assign load_use = id_valid && lu_hit;
    assign issue    = id_valid && !br_taken && !load_use;

    // Hazard outputs; freeze beats flush, flush beats load-use.
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (ext_stall) begin
            stall_if_id = 1'b1;
        end else if (br_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    // Next tracker contents: shift one stage, insert the ID instruction or a
    // bubble, and kill the wrong-path entries younger than a taken branch.
    always_comb begin
        ent_d = '0;
        if (issue) begin
            ent_d[0].v  = 1'b1;
            ent_d[0].rw = id_rw;
            ent_d[0].we = id_regwrite;
            ent_d[0].ld = id_memtoreg;
        end
        for (int k = 1; k < NSTAGE; k++) begin
            ent_d[k] = ent_q[k-1];
            if (br_taken && (k - 1 < BR_STAGE)) ent_d[k].v = 1'b0;
        end
        fwd_a_d = issue ? src_a_fwd : FWD_W'(FWD_RF);
        fwd_b_d = issue ? src_b_fwd : FWD_W'(FWD_RF);
    end

    // Tracker and select registers; a global freeze holds everything.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q   <= '0;
            fwd_a_q <= FWD_W'(FWD_RF);
            fwd_b_q <= FWD_W'(FWD_RF);
        end else if (!ext_stall) begin
            ent_q   <= ent_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Per-stage valid bits for the datapath.
    always_comb begin
        stg_valid = '0;
        for (int k = 0; k < NSTAGE; k++) stg_valid[k] = ent_q[k].v;
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (!ext_stall && !br_taken && load_use),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (!rst_n),
        .inc (!ext_stall && br_taken),
        .cnt (flush_cnt)
    );

endmodule
